// File: rtl/mm_resp_pkg.sv
// Shared types and constants for the main-memory line responder.
package mm_resp_pkg;

  localparam int unsigned LINE_BYTES = 32;
  localparam int unsigned OFFSET_W   = $clog2(LINE_BYTES);
  localparam int unsigned LAT_CNT_W  = 4;

  typedef enum logic [1:0] {
    StIdle,
    StRdWait,
    StWrWait,
    StResp
  } state_e;

endpackage

// File: rtl/mm_cap_buf.sv
// Capture buffer of accepted writes: {byte address, data word 0} per entry,
// with fill count, sticky overflow and clear.
module mm_cap_buf
  import mm_resp_pkg::*;
#(
  parameter int unsigned CAP_DEPTH = 16,
  localparam int unsigned IDX_W = $clog2(CAP_DEPTH),
  localparam int unsigned CNT_W = IDX_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cap_en,
  input  logic [31:0]      wr_addr,
  input  logic [31:0]      wr_data,
  input  logic             clear,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [31:0]      rd_addr,
  output logic [31:0]      rd_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             overflow
);

  logic [63:0]      mem_q [CAP_DEPTH];
  logic [CNT_W-1:0] count_q;
  logic             overflow_q;
  logic [IDX_W-1:0] wr_idx;
  logic             wr_en;

  assign full = (count_q == CNT_W'(CAP_DEPTH));

  // A clear in the same cycle as a capture restarts the buffer with that capture in slot 0.
  assign wr_idx = clear ? '0 : count_q[IDX_W-1:0];
  assign wr_en  = cap_en && (clear || !full);

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else if (clear) begin
      count_q    <= cap_en ? CNT_W'(1) : '0;
      overflow_q <= 1'b0;
    end else if (cap_en) begin
      if (full) begin
        overflow_q <= 1'b1;
      end else begin
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && wr_en) begin
      mem_q[wr_idx] <= {wr_addr, wr_data};
    end
  end

  assign rd_addr  = mem_q[rd_idx][63:32];
  assign rd_data  = mem_q[rd_idx][31:0];
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: rtl/mm_line_responder.sv
// Main-memory line responder: one request at a time, fixed read/write latency,
// valid/ready response channel, and a capture log of accepted writes.
module mm_line_responder
  import mm_resp_pkg::*;
#(
  parameter int unsigned ADDR_W    = 26,
  parameter int unsigned LINE_W    = 256,
  parameter int unsigned RD_LAT    = 4,
  parameter int unsigned WR_LAT    = 2,
  parameter int unsigned CAP_DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_wr,
  input  logic [ADDR_W-1:0]            req_addr,
  input  logic [LINE_W-1:0]            req_wd,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic                         rsp_wr,
  output logic [LINE_W-1:0]            rsp_rd,
  output logic                         mem_en,
  output logic                         mem_we,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [LINE_W-1:0]            mem_wd,
  input  logic [LINE_W-1:0]            mem_rd,
  input  logic [$clog2(CAP_DEPTH)-1:0] cap_idx,
  output logic [31:0]                  cap_addr,
  output logic [31:0]                  cap_data,
  output logic [$clog2(CAP_DEPTH):0]   cap_count,
  output logic                         cap_overflow,
  input  logic                         cap_clear
);

  localparam int unsigned BYTE_W = ADDR_W + OFFSET_W;
  localparam logic [LAT_CNT_W-1:0] RdLoad = LAT_CNT_W'(RD_LAT - 1);
  localparam logic [LAT_CNT_W-1:0] WrLoad = LAT_CNT_W'(WR_LAT - 1);

  state_e                 state_q, state_d;
  logic [LAT_CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [LINE_W-1:0]      wd_q, wd_d;
  logic [LINE_W-1:0]      rsp_rd_q, rsp_rd_d;
  logic                   rsp_wr_q, rsp_wr_d;
  logic                   mem_en_c, mem_we_c;
  logic                   accept;
  logic                   cap_full;
  logic [BYTE_W-1:0]      byte_full;
  logic [31:0]            cap_byte_addr;

  assign req_ready = (state_q == StIdle);
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wd_d     = wd_q;
    rsp_rd_d = rsp_rd_q;
    rsp_wr_d = rsp_wr_q;
    mem_en_c = 1'b0;
    mem_we_c = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          addr_d = req_addr;
          wd_d   = req_wd;
          if (req_wr) begin
            state_d = StWrWait;
            cnt_d   = WrLoad;
          end else begin
            state_d = StRdWait;
            cnt_d   = RdLoad;
          end
        end
      end
      StRdWait: begin
        // RAM read issued one cycle before the counter expires; its data is valid at expiry.
        mem_en_c = (cnt_q == LAT_CNT_W'(1));
        if (cnt_q == '0) begin
          rsp_rd_d = mem_rd;
          rsp_wr_d = 1'b0;
          state_d  = StResp;
        end else begin
          cnt_d = cnt_q - LAT_CNT_W'(1);
        end
      end
      StWrWait: begin
        // Counter still at its load value only in the first cycle after accept.
        mem_en_c = (cnt_q == WrLoad);
        mem_we_c = (cnt_q == WrLoad);
        if (cnt_q == '0) begin
          rsp_rd_d = '0;
          rsp_wr_d = 1'b1;
          state_d  = StResp;
        end else begin
          cnt_d = cnt_q - LAT_CNT_W'(1);
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      rsp_rd_q <= '0;
      rsp_wr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rsp_rd_q <= rsp_rd_d;
      rsp_wr_q <= rsp_wr_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    wd_q   <= wd_d;
  end

  // Gating by reset stops a RAM access in the very cycle reset is applied.
  assign mem_en    = mem_en_c && !reset;
  assign mem_we    = mem_we_c && !reset;
  assign mem_addr  = addr_q;
  assign mem_wd    = wd_q;
  assign rsp_valid = (state_q == StResp);
  assign rsp_wr    = rsp_wr_q;
  assign rsp_rd    = rsp_rd_q;

  assign byte_full = {req_addr, {OFFSET_W{1'b0}}};

  if (BYTE_W >= 32) begin : gen_addr_trunc
    assign cap_byte_addr = byte_full[31:0];
  end else begin : gen_addr_ext
    assign cap_byte_addr = {{(32 - BYTE_W){1'b0}}, byte_full};
  end

  mm_cap_buf #(
    .CAP_DEPTH (CAP_DEPTH)
  ) u_cap_buf (
    .clk      (clk),
    .reset    (reset),
    .cap_en   (accept && req_wr),
    .wr_addr  (cap_byte_addr),
    .wr_data  (req_wd[31:0]),
    .clear    (cap_clear),
    .rd_idx   (cap_idx),
    .rd_addr  (cap_addr),
    .rd_data  (cap_data),
    .count    (cap_count),
    .full     (cap_full),
    .overflow (cap_overflow)
  );

  logic unused_full;
  assign unused_full = cap_full;

endmodule

// File: tb/tb_mm_line_responder.sv
// Self-checking bench for mm_line_responder: vector table plus hand-written corner sequences.
module tb_mm_line_responder;

  localparam int unsigned ADDR_W    = 26;
  localparam int unsigned LINE_W    = 256;
  localparam int unsigned RD_LAT    = 4;
  localparam int unsigned WR_LAT    = 2;
  localparam int unsigned CAP_DEPTH = 16;
  localparam int unsigned IDX_W     = $clog2(CAP_DEPTH);

  localparam logic [255:0] L0 =
    256'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0_01234567_89abcdef_fedcba98_765432a5;
  localparam logic [255:0] L1 =
    256'h11112222_33334444_55556666_77778888_9999aaaa_bbbbcccc_ddddeeee_deadbeef;
  localparam logic [255:0] L2 =
    256'hcafef00d_00000001_80000000_7fffffff_a5a5a5a5_5a5a5a5a_0badc0de_13579bdf;
  localparam logic [255:0] L3 =
    256'h2468ace0_feedface_01010101_10101010_33333333_cccccccc_87654321_0000ff00;
  localparam logic [255:0] L4 =
    256'hffffffff_00000000_ffffffff_00000000_12121212_34343434_56565656_c001d00d;
  localparam logic [255:0] L5 =
    256'h9e3779b9_7f4a7c15_f39cc060_5cedc834_1082276b_f3a27251_f86c6a11_abad1dea;

  logic                 clk;
  logic                 reset;
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_wr;
  logic [ADDR_W-1:0]    req_addr;
  logic [LINE_W-1:0]    req_wd;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic                 rsp_wr;
  logic [LINE_W-1:0]    rsp_rd;
  logic                 mem_en;
  logic                 mem_we;
  logic [ADDR_W-1:0]    mem_addr;
  logic [LINE_W-1:0]    mem_wd;
  logic [LINE_W-1:0]    mem_rd;
  logic [IDX_W-1:0]     cap_idx;
  logic [31:0]          cap_addr;
  logic [31:0]          cap_data;
  logic [IDX_W:0]       cap_count;
  logic                 cap_overflow;
  logic                 cap_clear;

  mm_line_responder #(
    .ADDR_W    (ADDR_W),
    .LINE_W    (LINE_W),
    .RD_LAT    (RD_LAT),
    .WR_LAT    (WR_LAT),
    .CAP_DEPTH (CAP_DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_wr       (req_wr),
    .req_addr     (req_addr),
    .req_wd       (req_wd),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_wr       (rsp_wr),
    .rsp_rd       (rsp_rd),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wd       (mem_wd),
    .mem_rd       (mem_rd),
    .cap_idx      (cap_idx),
    .cap_addr     (cap_addr),
    .cap_data     (cap_data),
    .cap_count    (cap_count),
    .cap_overflow (cap_overflow),
    .cap_clear    (cap_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Line RAM: 64 slots keyed by addr[5:0], tagged with addr[25:6]; a tag miss returns all ones.
  logic [255:0] ram_d [64];
  logic [19:0]  ram_t [64];
  int unsigned  cyc = 0;
  int unsigned  men_cnt = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_en) begin
      men_cnt <= men_cnt + 1;
      if (mem_we) begin
        ram_d[mem_addr[5:0]] <= mem_wd;
        ram_t[mem_addr[5:0]] <= mem_addr[25:6];
      end else begin
        mem_rd <= (ram_t[mem_addr[5:0]] == mem_addr[25:6]) ? ram_d[mem_addr[5:0]] : {256{1'b1}};
      end
    end
  end

  function automatic logic [255:0] ram_peek(input logic [25:0] a);
    return (ram_t[a[5:0]] == a[25:6]) ? ram_d[a[5:0]] : {256{1'b1}};
  endfunction

  typedef struct {
    bit          wr;
    logic [25:0] addr;
    logic [255:0] line;
    int unsigned cyc;
  } sb_t;

  typedef struct {
    bit          wr;
    logic [25:0] addr;
    logic [255:0] line;  // write data, or expected read data
    int          stall;
  } vec_t;

  sb_t sb_q[$];
  int  total = 0;
  int  bad = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic do_req(input bit wr, input logic [25:0] addr, input logic [255:0] line,
                        input bit clr);
    bit acc;
    int n;
    sb_t it;
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = addr;
    req_wd    = wr ? line : {$urandom(), $urandom(), $urandom(), $urandom(),
                             $urandom(), $urandom(), $urandom(), $urandom()};
    cap_clear = clr;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 20) begin
      acc = req_ready;
      @(posedge clk);
      #1;
      n++;
    end
    req_valid = 1'b0;
    cap_clear = 1'b0;
    chk("accept", acc, 1'b1);
    if (acc) begin
      it.wr = wr;
      it.addr = addr;
      it.line = line;
      it.cyc = cyc;
      sb_q.push_back(it);
    end
  endtask

  task automatic get_rsp(input int stall);
    int n;
    sb_t it;
    logic [255:0] exp_rd;
    n = 0;
    while (!rsp_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!rsp_valid) begin
      chk("rsp_timeout", rsp_valid, 1'b1);
      return;
    end
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_rsp: got rsp_valid=1 want no pending request");
      return;
    end
    it = sb_q.pop_front();
    exp_rd = it.wr ? '0 : it.line;
    chk("latency", 256'(cyc - it.cyc), it.wr ? 256'(WR_LAT) : 256'(RD_LAT));
    chk("rsp_wr", rsp_wr, it.wr);
    chk("rsp_rd", rsp_rd, exp_rd);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      chk("stall_valid", rsp_valid, 1'b1);
      chk("stall_rd", rsp_rd, exp_rd);
      chk("stall_wr", rsp_wr, it.wr);
      chk("stall_req_ready", req_ready, 1'b0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk("rsp_drop", rsp_valid, 1'b0);
    chk("ready_back", req_ready, 1'b1);
    if (it.wr) chk("ram_line", ram_peek(it.addr), it.line);
  endtask

  task automatic fill(input logic [25:0] base, input int n);
    logic [255:0] line;
    for (int i = 0; i < n; i++) begin
      line = {{7{32'hc0c0_0000 + 32'(i)}}, 32'h1000_0000 + 32'(i)};
      do_req(1'b1, base + 26'(i), line, 1'b0);
      get_rsp(0);
    end
  endtask

  task automatic clear_pulse();
    cap_clear = 1'b1;
    @(posedge clk);
    #1;
    cap_clear = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[10];
    int k;
    int unsigned m0;
    logic [25:0] a;
    sb_t dropped;

    vecs[0] = '{wr: 1'b1, addr: 26'h0000003, line: L0, stall: 0};
    vecs[1] = '{wr: 1'b0, addr: 26'h0000003, line: L0, stall: 0};
    vecs[2] = '{wr: 1'b1, addr: 26'h0004000, line: L1, stall: 1};
    vecs[3] = '{wr: 1'b0, addr: 26'h0004000, line: L1, stall: 3};
    vecs[4] = '{wr: 1'b1, addr: 26'h3ffffff, line: L2, stall: 0};
    vecs[5] = '{wr: 1'b0, addr: 26'h3ffffff, line: L2, stall: 1};
    vecs[6] = '{wr: 1'b1, addr: 26'h0000015, line: L3, stall: 2};
    vecs[7] = '{wr: 1'b0, addr: 26'h0000015, line: L3, stall: 0};
    vecs[8] = '{wr: 1'b1, addr: 26'h0000003, line: L4, stall: 0};
    vecs[9] = '{wr: 1'b0, addr: 26'h0000003, line: L4, stall: 0};

    reset = 1'b1;
    req_valid = 1'b0;
    req_wr = 1'b0;
    req_addr = '0;
    req_wd = '0;
    rsp_ready = 1'b0;
    cap_idx = '0;
    cap_clear = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_wr", rsp_wr, 1'b0);
    chk("rst_rsp_rd", rsp_rd, '0);
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_cap_count", cap_count, '0);
    chk("rst_cap_overflow", cap_overflow, 1'b0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      do_req(vecs[i].wr, vecs[i].addr, vecs[i].line, 1'b0);
      get_rsp(vecs[i].stall);
    end

    // Capture log holds the table's writes in order.
    chk("tbl_cap_count", cap_count, 5);
    chk("tbl_cap_overflow", cap_overflow, 1'b0);
    k = 0;
    foreach (vecs[i]) begin
      if (vecs[i].wr) begin
        cap_idx = IDX_W'(k);
        #1;
        chk("tbl_cap_addr", cap_addr, {1'b0, vecs[i].addr, 5'b0});
        chk("tbl_cap_data", cap_data, vecs[i].line[31:0]);
        k++;
      end
    end
    cap_idx = IDX_W'(1);
    #1;
    chk("cap1_addr_const", cap_addr, 32'h0008_0000);
    chk("cap1_data_const", cap_data, 32'hdead_beef);

    // Response held 5 cycles while a second request waits; it must not be taken.
    do_req(1'b0, 26'h0004000, L1, 1'b0);
    req_valid = 1'b1;
    req_wr = 1'b0;
    req_addr = 26'h0000003;
    get_rsp(5);
    req_valid = 1'b0;
    m0 = men_cnt;
    repeat (3) @(posedge clk);
    #1;
    chk("no_stray_accept", 256'(men_cnt), 256'(m0));
    chk("idle_after_stall", req_ready, 1'b1);

    // Overflow: 17 writes into an emptied buffer.
    clear_pulse();
    chk("clr_count", cap_count, '0);
    fill(26'h0000220, 17);
    chk("full_count", cap_count, 16);
    chk("full_overflow", cap_overflow, 1'b1);
    chk("ram_17th", ram_peek(26'h0000230), {{7{32'hc0c0_0010}}, 32'h1000_0010});
    for (int i = 0; i < 16; i++) begin
      cap_idx = IDX_W'(i);
      a = 26'h0000220 + 26'(i);
      #1;
      chk("full_cap_addr", cap_addr, {1'b0, a, 5'b0});
      chk("full_cap_data", cap_data, 32'h1000_0000 + 32'(i));
    end
    clear_pulse();
    chk("clr_full_count", cap_count, '0);
    chk("clr_full_overflow", cap_overflow, 1'b0);

    // Clear coinciding with a write accept keeps that write as entry 0.
    fill(26'h0000260, 17);
    chk("refill_overflow", cap_overflow, 1'b1);
    do_req(1'b1, 26'h00002a0, L5, 1'b1);
    get_rsp(0);
    chk("clrwr_count", cap_count, 1);
    chk("clrwr_overflow", cap_overflow, 1'b0);
    cap_idx = '0;
    #1;
    chk("clrwr_cap_addr", cap_addr, 32'h0000_5400);
    chk("clrwr_cap_data", cap_data, L5[31:0]);

    // Reset during RD_WAIT drops the pending read before its RAM access.
    do_req(1'b0, 26'h0000015, L3, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    m0 = men_cnt;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rstmid_rsp_valid", rsp_valid, 1'b0);
    chk("rstmid_req_ready", req_ready, 1'b1);
    chk("rstmid_mem_en", mem_en, 1'b0);
    chk("rstmid_cap_count", cap_count, '0);
    repeat (6) @(posedge clk);
    #1;
    chk("rstmid_no_mem_en", 256'(men_cnt), 256'(m0));
    chk("rstmid_still_idle", rsp_valid, 1'b0);
    chk("rstmid_sb_pending", 256'(sb_q.size()), 256'(1));
    if (sb_q.size() > 0) dropped = sb_q.pop_back();
    do_req(1'b0, 26'h0000015, L3, 1'b0);
    get_rsp(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
